// File: rtl/ysyx_22040237_lsu_if.sv
// Pipeline-side (EXU in, WBU out) and memory-port signals of the LSU in one bundle.
// The LSU uses the master view; the surrounding pipeline and memory use the slave view.
interface ysyx_22040237_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_alu_result;
  logic [63:0] in_store_data;
  logic        in_mem_ren;
  logic        in_mem_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_rd_data;
  logic [1:0]  out_err;

  modport master (
    input  in_valid, in_pc, in_alu_result, in_store_data, in_mem_ren, in_mem_wen,
           in_size, in_unsigned, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wmask, out_valid, out_pc, out_rd_data, out_err
  );

  modport slave (
    output in_valid, in_pc, in_alu_result, in_store_data, in_mem_ren, in_mem_wen,
           in_size, in_unsigned, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wmask, out_valid, out_pc, out_rd_data, out_err
  );
endinterface

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: one instruction in flight, one aligned 64-bit memory access,
// result handed to write-back over valid/ready.
module ysyx_22040237_lsu #(
  parameter int unsigned RSP_TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22040237_lsu_if.master        bus,
  output logic [1:0]                 dbg_state_o
);

  // Handshakes: a valid/ready transfer happens on a rising edge where both are high;
  // a producer holds valid and its payload stable until that edge. The memory
  // response has no ready and is only looked at while waiting in S_RSP.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [63:0] req_wdata_q, req_wdata_d;
  logic [7:0]  req_wmask_q, req_wmask_d;
  logic        req_wen_q, req_wen_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] rd_q, rd_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        in_is_mem;
  logic        in_is_store;
  logic        in_misaligned;
  logic [2:0]  in_off;
  logic [7:0]  in_base_mask;

  // Decode of the instruction presented by the EXU; ren dominates wen.
  always_comb begin
    in_off      = bus.in_alu_result[2:0];
    in_is_mem   = bus.in_mem_ren | bus.in_mem_wen;
    in_is_store = bus.in_mem_wen & ~bus.in_mem_ren;
    case (bus.in_size)
      2'd0: begin
        in_misaligned = 1'b0;
        in_base_mask  = 8'h01;
      end
      2'd1: begin
        in_misaligned = in_off[0];
        in_base_mask  = 8'h03;
      end
      2'd2: begin
        in_misaligned = |in_off[1:0];
        in_base_mask  = 8'h0F;
      end
      default: begin
        in_misaligned = |in_off;
        in_base_mask  = 8'hFF;
      end
    endcase
  end

  logic [63:0] rsp_lane;
  logic [63:0] load_val;

  always_comb begin
    rsp_lane = bus.mem_rsp_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_val = uns_q ? {56'd0, rsp_lane[7:0]}  : {{56{rsp_lane[7]}},  rsp_lane[7:0]};
      2'd1:    load_val = uns_q ? {48'd0, rsp_lane[15:0]} : {{48{rsp_lane[15]}}, rsp_lane[15:0]};
      2'd2:    load_val = uns_q ? {32'd0, rsp_lane[31:0]} : {{32{rsp_lane[31]}}, rsp_lane[31:0]};
      default: load_val = rsp_lane;
    endcase
  end

  logic rsp_timeout;

  // Last waiting cycle: the counter has already seen RSP_TIMEOUT-1 empty cycles.
  always_comb begin
    rsp_timeout = 1'b0;
    if (RSP_TIMEOUT != 0) begin
      rsp_timeout = (cnt_q == 32'(RSP_TIMEOUT - 1));
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    req_wen_d   = req_wen_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          pc_d   = bus.in_pc;
          off_d  = in_off;
          size_d = bus.in_size;
          uns_d  = bus.in_unsigned;
          cnt_d  = '0;
          if (!in_is_mem) begin
            rd_d    = bus.in_alu_result;
            err_d   = ERR_OK;
            state_d = S_OUT;
          end else if (in_misaligned) begin
            rd_d    = '0;
            err_d   = ERR_MISALIGN;
            state_d = S_OUT;
          end else begin
            req_addr_d  = {bus.in_alu_result[63:3], 3'b000};
            req_wen_d   = in_is_store;
            req_wdata_d = in_is_store ? (bus.in_store_data << {in_off, 3'b000}) : '0;
            req_wmask_d = in_is_store ? (in_base_mask << in_off) : '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.mem_rsp_valid) begin
          rd_d    = req_wen_q ? 64'd0 : load_val;
          err_d   = ERR_OK;
          state_d = S_OUT;
        end else if (rsp_timeout) begin
          rd_d    = '0;
          err_d   = ERR_TIMEOUT;
          state_d = S_OUT;
        end else if (RSP_TIMEOUT != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      req_wen_q   <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      err_q       <= ERR_OK;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      req_wen_q   <= req_wen_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.out_valid     = (state_q == S_OUT);
  assign bus.out_pc        = pc_q;
  assign bus.out_rd_data   = rd_q;
  assign bus.out_err       = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Bench for ysyx_22040237_lsu: directed vector table, reset corner cases and
// randomized transactions checked against a byte-level reference model.
module tb_ysyx_22040237_lsu;

  localparam int TO = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  ysyx_22040237_lsu_if bus();

  ysyx_22040237_lsu #(.RSP_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic        ren;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    int          req_wait;
    int          rsp_wait;   // -1: memory never answers
    int          out_wait;
  } txn_t;

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rd;
    logic [1:0]  err;
    int          lat;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk_t(input logic [63:0] pc, alu, sdata, rdata,
                                input logic ren, wen, input logic [1:0] size,
                                input logic uns, input int rqw, rsw, ow);
    txn_t t;
    t.pc = pc; t.alu = alu; t.sdata = sdata; t.rdata = rdata;
    t.ren = ren; t.wen = wen; t.size = size; t.uns = uns;
    t.req_wait = rqw; t.rsp_wait = rsw; t.out_wait = ow;
    return t;
  endfunction

  function automatic exp_t mk_e(input logic req, input logic [63:0] addr, input logic wen,
                                input logic [63:0] wdata, input logic [7:0] wmask,
                                input logic [63:0] rd, input logic [1:0] err, input int lat);
    exp_t e;
    e.req = req; e.addr = addr; e.wen = wen; e.wdata = wdata; e.wmask = wmask;
    e.rd = rd; e.err = err; e.lat = lat;
    return e;
  endfunction

  task automatic add_vec(input txn_t t, input exp_t e);
    vec_t v;
    v.t = t;
    v.e = e;
    vecs.push_back(v);
  endtask

  // Reference: byte arithmetic on the access size and offset within the doubleword.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int          nb;
    int          off;
    logic [63:0] v;
    nb  = 1 << t.size;
    off = int'(t.alu[2:0]);
    e = mk_e(1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 64'd0, 2'd0, 1);
    if (!t.ren && !t.wen) begin
      e.rd = t.alu;
      return e;
    end
    if ((t.alu & 64'(nb - 1)) != 64'd0) begin
      e.err = 2'd1;
      return e;
    end
    e.req  = 1'b1;
    e.addr = t.alu - 64'(off);
    e.wen  = !t.ren;
    if (e.wen) begin
      e.wdata = t.sdata << (8 * off);
      e.wmask = 8'(((1 << nb) - 1) << off);
      e.rd    = 64'd0;
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = t.rdata[8*(off+i) +: 8];
      if (!t.uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
      e.rd = v;
    end
    if (t.rsp_wait < 0 || t.rsp_wait >= TO) begin
      e.err = 2'd2;
      e.rd  = 64'd0;
      e.lat = 2 + t.req_wait + TO;
    end else begin
      e.lat = 3 + t.req_wait + t.rsp_wait;
    end
    return e;
  endfunction

  task automatic drive_idle();
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_alu_result = '0;
    bus.in_store_data = '0;
    bus.in_mem_ren    = 1'b0;
    bus.in_mem_wen    = 1'b0;
    bus.in_size       = '0;
    bus.in_unsigned   = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.out_ready     = 1'b0;
  endtask

  // Called one step after a rising edge with the DUT idle; returns the same way.
  task automatic do_txn(input string nm, input txn_t t, input exp_t e);
    logic [63:0] r_addr, r_wdata, o_pc, o_rd, exp_rd;
    logic        r_wen;
    logic [7:0]  r_wmask;
    logic [1:0]  o_err;
    bit          saw_req, saw_out, fin, busy_bad, req_moved, out_moved, in_rsp, go_rsp;
    int          req_cnt, rsp_cnt, out_cnt, out_lat, n_hs;
    r_addr = '0; r_wdata = '0; o_pc = '0; o_rd = '0; r_wen = 0; r_wmask = '0; o_err = '0;
    saw_req = 0; saw_out = 0; fin = 0; busy_bad = 0; req_moved = 0; out_moved = 0;
    in_rsp = 0; go_rsp = 0; req_cnt = 0; rsp_cnt = 0; out_cnt = 0; out_lat = 0; n_hs = 0;
    exp_q.push_back(e.rd);

    chk({nm, ".in_ready_idle"}, bus.in_ready, 1'b1);
    bus.in_valid      = 1'b1;
    bus.in_pc         = t.pc;
    bus.in_alu_result = t.alu;
    bus.in_store_data = t.sdata;
    bus.in_mem_ren    = t.ren;
    bus.in_mem_wen    = t.wen;
    bus.in_size       = t.size;
    bus.in_unsigned   = t.uns;
    bus.mem_rsp_valid = 1'($urandom_range(0, 1));
    bus.mem_rsp_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.in_pc         = {$urandom, $urandom};
    bus.in_alu_result = {$urandom, $urandom};
    bus.in_store_data = {$urandom, $urandom};
    bus.in_mem_ren    = 1'($urandom_range(0, 1));
    bus.in_mem_wen    = 1'($urandom_range(0, 1));
    bus.in_size       = 2'($urandom_range(0, 3));
    bus.in_unsigned   = 1'($urandom_range(0, 1));

    for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
      if (go_rsp) begin
        in_rsp = 1;
        go_rsp = 0;
      end
      if (bus.out_valid) in_rsp = 0;
      if (bus.in_ready) busy_bad = 1;
      bus.in_valid      = 1'($urandom_range(0, 1));
      bus.mem_rsp_valid = 1'($urandom_range(0, 1));
      bus.mem_rsp_rdata = {$urandom, $urandom};
      bus.out_ready     = 1'b0;
      if (bus.mem_req_valid) begin
        if (!saw_req) begin
          saw_req = 1;
          r_addr  = bus.mem_req_addr;
          r_wen   = bus.mem_req_wen;
          r_wdata = bus.mem_req_wdata;
          r_wmask = bus.mem_req_wmask;
        end else if (bus.mem_req_addr !== r_addr || bus.mem_req_wen !== r_wen ||
                     bus.mem_req_wdata !== r_wdata || bus.mem_req_wmask !== r_wmask) begin
          req_moved = 1;
        end
        bus.mem_req_ready = (req_cnt >= t.req_wait);
        req_cnt++;
        if (bus.mem_req_ready) begin
          go_rsp = 1;
          n_hs++;
        end
      end else begin
        bus.mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (in_rsp) begin
        bus.mem_rsp_valid = (t.rsp_wait >= 0 && rsp_cnt == t.rsp_wait);
        if (bus.mem_rsp_valid) bus.mem_rsp_rdata = t.rdata;
        rsp_cnt++;
      end
      if (bus.out_valid) begin
        if (!saw_out) begin
          saw_out = 1;
          out_lat = cyc;
          o_pc    = bus.out_pc;
          o_rd    = bus.out_rd_data;
          o_err   = bus.out_err;
        end else if (bus.out_pc !== o_pc || bus.out_rd_data !== o_rd || bus.out_err !== o_err) begin
          out_moved = 1;
        end
        bus.out_ready = (out_cnt >= t.out_wait);
        out_cnt++;
        if (bus.out_ready) fin = 1;
      end
      @(posedge clk); #1;
    end
    drive_idle();

    chk({nm, ".completed"}, fin, 1'b1);
    chk({nm, ".single_completion"}, bus.out_valid, 1'b0);
    chk({nm, ".in_ready_after"}, bus.in_ready, 1'b1);
    chk({nm, ".busy_in_ready"}, busy_bad, 1'b0);
    chk({nm, ".req_issued"}, saw_req, e.req);
    if (e.req && saw_req) begin
      chk({nm, ".req_addr"}, r_addr, e.addr);
      chk({nm, ".req_wen"}, r_wen, e.wen);
      chk({nm, ".req_wmask"}, r_wmask, e.wmask);
      if (e.wen) chk({nm, ".req_wdata"}, r_wdata, e.wdata);
      chk({nm, ".req_stable"}, req_moved, 1'b0);
      chk({nm, ".req_handshakes"}, n_hs, 1);
    end
    exp_rd = exp_q.pop_front();
    chk({nm, ".out_rd_data"}, o_rd, exp_rd);
    chk({nm, ".out_err"}, o_err, e.err);
    chk({nm, ".out_pc"}, o_pc, t.pc);
    chk({nm, ".latency"}, out_lat, e.lat);
    chk({nm, ".out_stable"}, out_moved, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".mem_req_valid"}, bus.mem_req_valid, 1'b0);
    chk({nm, ".mem_req_wen"}, bus.mem_req_wen, 1'b0);
    chk({nm, ".mem_req_addr"}, bus.mem_req_addr, 64'd0);
    chk({nm, ".mem_req_wdata"}, bus.mem_req_wdata, 64'd0);
    chk({nm, ".mem_req_wmask"}, bus.mem_req_wmask, 8'd0);
    chk({nm, ".out_valid"}, bus.out_valid, 1'b0);
    chk({nm, ".out_pc"}, bus.out_pc, 64'd0);
    chk({nm, ".out_rd_data"}, bus.out_rd_data, 64'd0);
    chk({nm, ".out_err"}, bus.out_err, 2'd0);
    chk({nm, ".in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    txn_t t;
    int   kind;
    drive_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // pc, alu, sdata, rdata, ren, wen, size, uns, req_wait, rsp_wait, out_wait
    add_vec(mk_t(64'h1000, 64'h1234, 64'h0, 64'h0, 0, 0, 2'd3, 0, 0, 0, 0),
            mk_e(0, 64'h0, 0, 64'h0, 8'h00, 64'h1234, 2'd0, 1));
    add_vec(mk_t(64'h1004, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 2'd0, 0, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 3));
    add_vec(mk_t(64'h1008, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1, 0, 2'd0, 1, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 0, 64'h0, 8'h00, 64'h80, 2'd0, 3));
    add_vec(mk_t(64'h100C, 64'h8000_0006, 64'hABCD, 64'h0, 0, 1, 2'd1, 0, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 1, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0, 2'd0, 3));
    add_vec(mk_t(64'h1010, 64'h8000_0002, 64'h0, 64'h0, 1, 0, 2'd2, 0, 0, 0, 0),
            mk_e(0, 64'h0, 0, 64'h0, 8'h00, 64'h0, 2'd1, 1));
    add_vec(mk_t(64'h1014, 64'h8000_0010, 64'h0, 64'h1122_3344_5566_7788, 1, 0, 2'd3, 0, 3, 0, 2),
            mk_e(1, 64'h8000_0010, 0, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 2'd0, 6));
    add_vec(mk_t(64'h1018, 64'h8000_0004, 64'h0, 64'h0, 1, 0, 2'd2, 0, 0, -1, 0),
            mk_e(1, 64'h8000_0000, 0, 64'h0, 8'h00, 64'h0, 2'd2, 6));
    add_vec(mk_t(64'h101C, 64'h8000_000C, 64'h0, 64'h8765_4321_0000_0000, 1, 0, 2'd2, 0, 0, 3, 0),
            mk_e(1, 64'h8000_0008, 0, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 2'd0, 6));
    add_vec(mk_t(64'h1020, 64'h8000_0001, 64'hFF, 64'h0000_0000_0000_7F00, 1, 1, 2'd0, 0, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 0, 64'h0, 8'h00, 64'h7F, 2'd0, 3));
    add_vec(mk_t(64'h1024, 64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 1, 2'd3, 0, 1, 1, 1),
            mk_e(1, 64'h8000_0018, 1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h0, 2'd0, 5));
    add_vec(mk_t(64'h1028, 64'h8000_0007, 64'h1111_2222_3333_4411, 64'h0, 0, 1, 2'd0, 0, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 1, 64'h1100_0000_0000_0000, 8'h80, 64'h0, 2'd0, 3));
    add_vec(mk_t(64'h102C, 64'h8000_0004, 64'h5555_5555_1234_5678, 64'h0, 0, 1, 2'd2, 0, 0, 2, 0),
            mk_e(1, 64'h8000_0000, 1, 64'h1234_5678_0000_0000, 8'hF0, 64'h0, 2'd0, 5));
    add_vec(mk_t(64'h1030, 64'h8000_0006, 64'h0, 64'hF00D_0000_0000_0000, 1, 0, 2'd1, 1, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 0, 64'h0, 8'h00, 64'hF00D, 2'd0, 3));
    add_vec(mk_t(64'h1034, 64'h8000_0006, 64'h0, 64'hF00D_0000_0000_0000, 1, 0, 2'd1, 0, 0, 0, 0),
            mk_e(1, 64'h8000_0000, 0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D, 2'd0, 3));
    add_vec(mk_t(64'h1038, 64'h8000_0004, 64'h1, 64'h0, 0, 1, 2'd3, 0, 0, 0, 0),
            mk_e(0, 64'h0, 0, 64'h0, 8'h00, 64'h0, 2'd1, 1));

    foreach (vecs[i]) do_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e);

    // Reset while waiting for a response: everything clears, no completion follows.
    bus.in_valid      = 1'b1;
    bus.in_pc         = 64'h2000;
    bus.in_alu_result = 64'h8000_0020;
    bus.in_mem_ren    = 1'b1;
    bus.in_size       = 2'd3;
    @(posedge clk); #1;
    bus.in_valid      = 1'b0;
    chk("rst_mid.req_valid", bus.mem_req_valid, 1'b1);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    chk("rst_mid.in_rsp", bus.mem_req_valid | bus.in_ready | bus.out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_mid.no_out%0d", i), bus.out_valid, 1'b0);
    end
    drive_idle();
    t = mk_t(64'h2004, 64'h8000_0028, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, 2'd3, 0, 0, 3, 0);
    do_txn("rst_mid.after", t, mk_e(1, 64'h8000_0028, 0, 64'h0, 8'h00,
                                     64'h0123_4567_89AB_CDEF, 2'd0, 6));

    for (int n = 0; n < 40; n++) begin
      kind    = $urandom_range(0, 9);
      t.pc    = {32'd0, $urandom};
      t.sdata = {$urandom, $urandom};
      t.rdata = {$urandom, $urandom};
      t.size  = 2'($urandom_range(0, 3));
      t.uns   = 1'($urandom_range(0, 1));
      t.ren   = (kind >= 2 && kind <= 5) || kind == 9;
      t.wen   = kind >= 6;
      t.alu   = {32'd0, 32'h8000_0000 | 32'($urandom_range(0, 255))};
      if ($urandom_range(0, 3) != 0) t.alu = t.alu & ~64'((1 << t.size) - 1);
      if (kind <= 1) t.alu = {$urandom, $urandom};
      t.req_wait = $urandom_range(0, 3);
      t.rsp_wait = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      t.out_wait = $urandom_range(0, 2);
      do_txn($sformatf("rand%0d", n), t, model(t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_lsu.md
Name: ysyx_22040237_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Takes the EXU result (effective address, or plain rd data for non-memory instructions) plus store data and access attributes.
- Performs one access on a 64-bit aligned memory port with valid/ready request and valid response, then hands the write-back value to the WBU over a valid/ready interface.
- One instruction in flight at a time.

Parameters:
- RSP_TIMEOUT, 0, cycles to wait in RSP before aborting with a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  EXU presents an instruction
- in_ready  out  1  LSU can accept an instruction
- in_pc  in  64  PC of the instruction
- in_alu_result  in  64  effective address (memory op) or rd data (non-memory op)
- in_store_data  in  64  rs2 value; low bytes are used
- in_mem_ren  in  1  load
- in_mem_wen  in  1  store
- in_size  in  2  0=byte, 1=half, 2=word, 3=double
- in_unsigned  in  1  zero-extend the load (LBU/LHU/LWU)
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  64  request address, {addr[63:3],3'b0}
- mem_req_wen  out  1  request is a write
- mem_req_wdata  out  64  lane-shifted write data
- mem_req_wmask  out  8  byte-enable mask
- mem_rsp_valid  in  1  response (read data or write ack)
- mem_rsp_rdata  in  64  read data
- out_valid  out  1  write-back data valid
- out_ready  in  1  WBU accepts
- out_pc  out  64  PC of the completed instruction
- out_rd_data  out  64  value for rd
- out_err  out  2  0=ok, 1=misaligned, 2=timeout; valid with out_valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, out_valid=0, out_pc=0, out_rd_data=0, out_err=0, timeout counter=0. Reset mid-transaction abandons the access, and no out_valid follows.
- States: IDLE, REQ, RSP, OUT. in_ready=1 only in IDLE.
- IDLE, on in_valid:
  - Latch pc, addr, data and attributes.
  - Non-memory op: out_rd_data=in_alu_result, err=0, go to OUT.
  - Memory op, misaligned: the address is not a multiple of the size (size1: a[0]; size2: a[1:0]; size3: a[2:0]). No request is issued; out_rd_data=0, err=1, go to OUT.
  - Memory op, aligned: go to REQ.
  - If ren and wen are both set, ren wins and wen is ignored.
- REQ: mem_req_valid=1, and the request fields are held stable until the handshake. On mem_req_ready, go to RSP and clear mem_req_valid.
- RSP:
  - mem_rsp_valid is sampled only in this state; outside RSP it is ignored.
  - On mem_rsp_valid, go to OUT with err=0.
  - Load: take the byte lane at offset a[2:0] of mem_rsp_rdata, shifted right by a[2:0]*8. Sign-extend it to 64 bits, or zero-extend it when in_unsigned=1.
  - Store: out_rd_data=0.
- Timeout: when RSP_TIMEOUT>0, the counter increments each RSP cycle without mem_rsp_valid. When the count reaches RSP_TIMEOUT, go to OUT with err=2 and out_rd_data=0. A response arriving in the same cycle wins over the timeout. The counter clears on entering RSP.
- OUT: out_valid=1, and outputs are held until out_ready. On out_ready, go to IDLE. No new instruction is accepted in the same cycle.
- Write lanes: mem_req_wdata = store_data << (a[2:0]*8). mem_req_wmask = (1,3,0xF,0xFF for size 0..3) << a[2:0]. For reads, mem_req_wmask=0 and mem_req_wen=0.
- Latency, zero wait, from the accept edge:
  - non-memory: out_valid the next cycle;
  - memory: REQ +1, RSP +2, out_valid +3 when memory responds in its first RSP cycle.

Test Plan:
- Non-memory pass-through: in_alu_result=0x1234, ren=wen=0 -> out_valid 1 cycle after accept, out_rd_data=0x1234, err=0, no mem_req_valid.
- LB signed: addr=0x8000_0003, rdata=0x0000_0000_8000_0000 (byte3=0x80) -> req addr 0x8000_0000, wmask=0, out_rd_data=0xFFFF_FFFF_FFFF_FF80. Repeat with in_unsigned=1 -> 0x80.
- SH: addr=0x8000_0006, store_data=0xABCD -> wmask=0xC0, wdata=0xABCD_0000_0000_0000, wen=1, out_rd_data=0 after ack.
- Misaligned LW: addr=0x8000_0002 -> no request, out_err=1, out_rd_data=0.
- Backpressure: mem_req_ready low for 3 cycles, then out_ready low for 2 cycles -> request fields and outputs stay stable, in_ready=0 throughout, exactly one completion.
- Timeout (RSP_TIMEOUT=4), no response -> out_err=2 after 4 RSP cycles. Separately, assert rst during RSP -> all outputs reset to 0 immediately, then a normal load completes.
